// File: rtl/counter_bin_behav.sv
// counter_bin_behav: free-running WIDTH-bit up-counter wrapping mod 2**WIDTH; ports clk, rst (sync active-high clear), count
module counter_bin_behav #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  output logic [WIDTH-1:0] count
);
  always_ff @(posedge clk)
    count <= rst ? '0 : count + 1'b1;
endmodule

// File: tb/tb_counter_bin_behav.sv
// tb_counter_bin_behav: table-driven check of counter_bin_behav at WIDTH=4 and WIDTH=3
module tb_counter_bin_behav;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rst3 = 1'b1;
  logic [3:0] count;
  logic [2:0] count3;
  int checks = 0;
  int passed = 0;

  typedef struct packed {
    logic       rst;
    logic [3:0] cnt;
  } vec_t;

  typedef struct packed {
    logic       rst;
    logic [2:0] cnt;
  } vec3_t;

  vec_t vec[29] = '{
    '{1'b1, 4'd0}, '{1'b1, 4'd0},
    '{1'b0, 4'd1}, '{1'b0, 4'd2}, '{1'b0, 4'd3}, '{1'b0, 4'd4}, '{1'b0, 4'd5},
    '{1'b0, 4'd6}, '{1'b0, 4'd7}, '{1'b0, 4'd8}, '{1'b0, 4'd9}, '{1'b0, 4'd10},
    '{1'b0, 4'd11}, '{1'b0, 4'd12}, '{1'b0, 4'd13}, '{1'b0, 4'd14}, '{1'b0, 4'd15},
    '{1'b0, 4'd0}, '{1'b0, 4'd1}, '{1'b0, 4'd2}, '{1'b0, 4'd3}, '{1'b0, 4'd4},
    '{1'b0, 4'd5}, '{1'b0, 4'd6}, '{1'b0, 4'd7},
    '{1'b1, 4'd0}, '{1'b1, 4'd0},
    '{1'b0, 4'd1}, '{1'b0, 4'd2}
  };

  vec3_t vec3[11] = '{
    '{1'b1, 3'd0},
    '{1'b0, 3'd1}, '{1'b0, 3'd2}, '{1'b0, 3'd3}, '{1'b0, 3'd4},
    '{1'b0, 3'd5}, '{1'b0, 3'd6}, '{1'b0, 3'd7}, '{1'b0, 3'd0},
    '{1'b1, 3'd0}, '{1'b0, 3'd1}
  };

  counter_bin_behav dut (
    .clk  (clk),
    .rst  (rst),
    .count(count)
  );

  counter_bin_behav #(.WIDTH(3)) dut3 (
    .clk  (clk),
    .rst  (rst3),
    .count(count3)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  initial begin
    for (int i = 0; i < 29; i++) begin
      rst = vec[i].rst;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("w4_vec%0d", i), int'(count), int'(vec[i].cnt));
    end
    #1 rst = 1'b1;
    #2 rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("async_pulse_ignored", int'(count), 3);
    @(posedge clk);
    @(negedge clk);
    check("after_pulse", int'(count), 4);
    for (int i = 0; i < 11; i++) begin
      rst3 = vec3[i].rst;
      @(posedge clk);
      @(negedge clk);
      check($sformatf("w3_vec%0d", i), int'(count3), int'(vec3[i].cnt));
    end
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
